// File: rtl/keypad_to_data_if.sv
// Keypad-side and host-side signals of keypad_to_data.
// The master modport belongs to the scanner, and the slave modport belongs to the keypad/host model.
interface keypad_to_data_if #(
  parameter int Size = 8
);
  logic [3:0]      Rows;
  logic [3:0]      Columns;
  logic [Size-1:0] Data;
  logic            Valid;
  logic [3:0]      KeyCode;
  logic            KeyStrobe;
  logic            Overflow;
  logic            DebugState;

  // Strobes are single-cycle pulses with no back-pressure: KeyStrobe marks an accepted press,
  // and Valid (coincident with the '#' KeyStrobe) marks a new Data word.
  modport master (input Rows, output Columns, Data, Valid, KeyCode, KeyStrobe, Overflow, DebugState);
  modport slave  (output Rows, input Columns, Data, Valid, KeyCode, KeyStrobe, Overflow, DebugState);
endinterface

// File: rtl/keypad_to_data.sv
// 4x4 keypad scanner with debounce and decimal entry accumulator.
// Optional macro KEYPAD_BACKSPACE_EN: key B divides the entry by ten and clears Overflow.
module keypad_to_data #(
  parameter int    Size           = 8,
  parameter string Signed         = "Yes",
  parameter int    ClockPeriod_ns = 20,
  parameter int    ScanTime_ns    = 1_000_000,
  parameter int    DebounceScans  = 4
) (
  input logic              Clock,
  input logic              Reset,
  keypad_to_data_if.master bus
);
  localparam int PrescaleRaw = ScanTime_ns / ClockPeriod_ns;
  localparam int Prescale    = (PrescaleRaw < 2) ? 2 : PrescaleRaw;
  localparam int PW          = $clog2(Prescale);
  localparam int AW          = Size + 4;
  localparam bit IsSigned    = (Signed == "Yes");
  localparam logic [AW-1:0] MaxVal = IsSigned ? ((AW'(1) << (Size - 1)) - AW'(1))
                                              : ((AW'(1) << Size) - AW'(1));
  // Key code for each snapshot bit; the bit index is row*4+column, and nibble 0 is row 0 / column 0.
  localparam logic [63:0] KeyMap = 64'hDF0E_C987_B654_A321;

  typedef enum logic {S_IDLE, S_PRESSED} state_t;

  logic [3:0]      r_rows_m, r_rows_s;
  logic [PW-1:0]   r_pre;
  logic [1:0]      r_col;
  logic [15:0]     r_snap;
  state_t          r_state;
  logic [3:0]      r_cnt, r_cand;
  logic [Size-1:0] r_acc, r_data;
  logic            r_sign, r_ovf, r_valid, r_strobe;
  logic [3:0]      r_code;

  logic            w_tick, w_scan_done, w_single, w_event;
  logic [15:0]     w_snap_next, w_pressed;
  logic [4:0]      w_n_keys;
  logic [3:0]      w_idx, w_code, w_cnt_nx, w_cand_nx;
  state_t          w_state_nx;
  logic [AW-1:0]   w_mul;

  assign w_tick      = (r_pre == PW'(Prescale - 1));
  assign w_scan_done = w_tick && (r_col == 2'd3);

  // After the column-3 sample is merged in, the snapshot holds a complete scan.
  always_comb begin
    w_snap_next = r_snap;
    for (int r = 0; r < 4; r++) w_snap_next[{2'(r), r_col}] = r_rows_s[r];
    w_pressed = ~w_snap_next;
    w_n_keys  = '0;
    w_idx     = '0;
    for (int i = 0; i < 16; i++) begin
      if (w_pressed[i]) begin
        w_n_keys = w_n_keys + 5'd1;
        w_idx    = 4'(i);
      end
    end
    w_single = (w_n_keys == 5'd1);
    w_code   = KeyMap[{w_idx, 2'b00} +: 4];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rows_m <= '1;
      r_rows_s <= '1;
      r_pre    <= '0;
      r_col    <= '0;
      r_snap   <= '1;
    end else begin
      r_rows_m <= bus.Rows;
      r_rows_s <= r_rows_m;
      if (w_tick) begin
        r_pre  <= '0;
        r_col  <= r_col + 2'd1;
        r_snap <= w_snap_next;
      end else begin
        r_pre <= r_pre + PW'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_cand  <= w_cand_nx;
    end
  end

  // A multi-key scan counts as NONE, so it also counts towards a release.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_cand_nx  = r_cand;
    w_event    = 1'b0;
    if (w_scan_done) begin
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            w_cand_nx = w_code;
            w_cnt_nx  = (w_code == r_cand && r_cnt != 4'd0) ? r_cnt + 4'd1 : 4'd1;
            if (w_cnt_nx == 4'(DebounceScans)) begin
              w_state_nx = S_PRESSED;
              w_cnt_nx   = '0;
              w_event    = 1'b1;
            end
          end else begin
            w_cnt_nx = '0;
          end
        end
        S_PRESSED: begin
          if (!w_single) begin
            w_cnt_nx = r_cnt + 4'd1;
            if (w_cnt_nx == 4'(DebounceScans)) begin
              w_state_nx = S_IDLE;
              w_cnt_nx   = '0;
            end
          end else begin
            w_cnt_nx = '0;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  assign w_mul = {4'b0, r_acc} * AW'(10) + AW'(w_code);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_acc <= '0; r_sign <= 1'b0; r_ovf <= 1'b0; r_data <= '0;
      r_valid <= 1'b0; r_strobe <= 1'b0; r_code <= '0;
    end else begin
      r_strobe <= w_event;
      r_valid  <= 1'b0;
      // Overflow stays visible for the whole Valid cycle, then drops.
      if (r_valid) r_ovf <= 1'b0;
      if (w_event) begin
        r_code <= w_code;
        if (w_code <= 4'd9) begin
          if (w_mul > MaxVal) begin
            r_acc <= MaxVal[Size-1:0];
            r_ovf <= 1'b1;
          end else begin
            r_acc <= w_mul[Size-1:0];
          end
        end else begin
          case (w_code)
            4'd10: if (IsSigned) r_sign <= ~r_sign;
            4'd14: begin
              r_acc <= '0; r_sign <= 1'b0; r_ovf <= 1'b0;
            end
            4'd15: begin
              r_data  <= r_sign ? (~r_acc + 1'b1) : r_acc;
              r_valid <= 1'b1;
              r_acc   <= '0;
              r_sign  <= 1'b0;
            end
`ifdef KEYPAD_BACKSPACE_EN
            4'd11: begin
              r_acc <= r_acc / Size'(10);
              r_ovf <= 1'b0;
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.Columns    = ~(4'b0001 << r_col);
  assign bus.Data       = r_data;
  assign bus.Valid      = r_valid;
  assign bus.KeyCode    = r_code;
  assign bus.KeyStrobe  = r_strobe;
  assign bus.Overflow   = r_ovf;
  assign bus.DebugState = (r_state == S_PRESSED);
endmodule

// File: tb/tb_keypad_to_data.sv
// Bench for keypad_to_data: an unsigned and a signed instance share one keypad model.
// Expected events come from a scan-level reference model; KEYPAD_BACKSPACE_EN selects the B behaviour.
module tb_keypad_to_data;
  localparam int N_DEB = 4;

  typedef struct packed {
    logic [3:0] code;
    logic       valid;
    logic [7:0] data;
    logic       ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0;
  int          n_checks = 0;
  int          n_err = 0;
  exp_t        exp_u_q[$];
  exp_t        exp_s_q[$];
  int          hist[$];
  bit          m_pressed = 1'b0;
  int          m_acc[2] = '{0, 0};
  bit          m_sign[2] = '{0, 0};
  bit          m_ovf[2] = '{0, 0};
  bit          prev_valid[2] = '{0, 0};
  int          n_strobe[2] = '{0, 0};
  int          n_valid[2] = '{0, 0};
  int          key_tab[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  keypad_to_data_if #(.Size(8)) bus_u ();
  keypad_to_data_if #(.Size(8)) bus_s ();

  keypad_to_data #(.Size(8), .Signed("No"), .ClockPeriod_ns(20), .ScanTime_ns(200),
                   .DebounceScans(N_DEB)) dut_u (.Clock(clk), .Reset(rst), .bus(bus_u));
  keypad_to_data #(.Size(8), .Signed("Yes"), .ClockPeriod_ns(20), .ScanTime_ns(200),
                   .DebounceScans(N_DEB)) dut_s (.Clock(clk), .Reset(rst), .bus(bus_s));

  always #10 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  function automatic logic [3:0] rows_of(input logic [15:0] k, input logic [3:0] cols);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 16; i++) if (k[i] && !cols[i % 4]) r[i / 4] = 1'b0;
    return r;
  endfunction

  assign bus_u.Rows = rows_of(keys, bus_u.Columns);
  assign bus_s.Rows = rows_of(keys, bus_s.Columns);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pos_of(input int code);
    for (int i = 0; i < 16; i++) if (key_tab[i] == code) return i;
    return 0;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_pressed = 1'b0;
    for (int id = 0; id < 2; id++) begin
      m_acc[id] = 0; m_sign[id] = 1'b0; m_ovf[id] = 1'b0;
    end
  endtask

  task automatic apply_event(input int code);
    for (int id = 0; id < 2; id++) begin
      int   mx;
      exp_t e;
      mx = (id == 1) ? 127 : 255;
      e.code = 4'(code); e.valid = 1'b0; e.data = 8'h00;
      if (code <= 9) begin
        m_acc[id] = m_acc[id] * 10 + code;
        if (m_acc[id] > mx) begin
          m_acc[id] = mx;
          m_ovf[id] = 1'b1;
        end
      end else if (code == 10) begin
        if (id == 1) m_sign[id] = !m_sign[id];
      end else if (code == 14) begin
        m_acc[id] = 0; m_sign[id] = 1'b0; m_ovf[id] = 1'b0;
      end else if (code == 15) begin
        e.valid = 1'b1;
        e.data  = 8'(m_sign[id] ? -m_acc[id] : m_acc[id]);
      end
`ifdef KEYPAD_BACKSPACE_EN
      else if (code == 11) begin
        m_acc[id] = m_acc[id] / 10;
        m_ovf[id] = 1'b0;
      end
`endif
      e.ovf = m_ovf[id];
      if (code == 15) begin
        m_acc[id] = 0; m_sign[id] = 1'b0; m_ovf[id] = 1'b0;
      end
      if (id == 0) exp_u_q.push_back(e);
      else exp_s_q.push_back(e);
    end
  endtask

  // A press (or release) is accepted once the last N_DEB scans agree.
  task automatic model_scan(input logic [15:0] m);
    int cls;
    bit same;
    cls = -1;
    if ($countones(m) == 1)
      for (int i = 0; i < 16; i++) if (m[i]) cls = key_tab[i];
    hist.push_back(cls);
    if (hist.size() > N_DEB) void'(hist.pop_front());
    same = (hist.size() == N_DEB);
    foreach (hist[i]) if (hist[i] != cls) same = 1'b0;
    if (!m_pressed && same && cls >= 0) begin
      m_pressed = 1'b1;
      apply_event(cls);
    end else if (m_pressed && same && cls < 0) begin
      m_pressed = 1'b0;
    end
  endtask

  task automatic wait_boundary();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus_s.Columns == 4'b0111) seen = 1'b1;
      else if (seen && bus_s.Columns == 4'b1110) return;
    end
    check("scan_boundary_timeout", 0, 1);
  endtask

  task automatic scan(input logic [15:0] m);
    wait_boundary();
    keys = m;
    model_scan(m);
  endtask

  task automatic enter(input int code);
    repeat (6) scan(16'(1) << pos_of(code));
    repeat (6) scan(16'h0000);
  endtask

  task automatic mon_dut(input int id, input logic stb, input logic [3:0] code,
                         input logic vld, input logic [7:0] data, input logic ovf);
    exp_t  e;
    string p;
    bit    empty;
    p = (id == 1) ? "s" : "u";
    if (prev_valid[id]) check({p, "_ovf_clear_after_valid"}, 32'(ovf), 0);
    prev_valid[id] = vld;
    if (stb) begin
      n_strobe[id]++;
      if (vld) n_valid[id]++;
      empty = (id == 0) ? (exp_u_q.size() == 0) : (exp_s_q.size() == 0);
      if (empty) begin
        check({p, "_unexpected_strobe"}, 1, 0);
      end else begin
        if (id == 0) e = exp_u_q.pop_front();
        else e = exp_s_q.pop_front();
        check({p, "_keycode"}, 32'(code), 32'(e.code));
        check({p, "_valid"}, 32'(vld), 32'(e.valid));
        if (e.valid) check({p, "_data"}, 32'(data), 32'(e.data));
        check({p, "_overflow"}, 32'(ovf), 32'(e.ovf));
      end
    end else if (vld) begin
      check({p, "_valid_without_strobe"}, 1, 0);
    end
  endtask

  initial begin
    int s0, s1, v0, v1;
    fork
      forever begin
        @(negedge clk);
        mon_dut(0, bus_u.KeyStrobe, bus_u.KeyCode, bus_u.Valid, bus_u.Data, bus_u.Overflow);
        mon_dut(1, bus_s.KeyStrobe, bus_s.KeyCode, bus_s.Valid, bus_s.Data, bus_s.Overflow);
      end
    join_none

    // Reset asserted mid-scan, then column stepping.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_columns", 32'(bus_s.Columns), 32'hE);
    check("rst_data_u", 32'(bus_u.Data), 0);
    check("rst_data_s", 32'(bus_s.Data), 0);
    check("rst_valid", 32'(bus_s.Valid), 0);
    check("rst_overflow", 32'(bus_s.Overflow), 0);
    check("rst_keycode", 32'(bus_s.KeyCode), 0);
    check("rst_keystrobe", 32'(bus_s.KeyStrobe), 0);
    check("rst_debug_state", 32'(bus_s.DebugState), 0);
    rst = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    check("col_step0", 32'(bus_u.Columns), 32'hE);
    repeat (10) @(negedge clk);
    check("col_step1", 32'(bus_u.Columns), 32'hD);
    repeat (10) @(negedge clk);
    check("col_step2", 32'(bus_u.Columns), 32'hB);
    repeat (10) @(negedge clk);
    check("col_step3", 32'(bus_u.Columns), 32'h7);

    // Entry 1, 2, 7, #.
    s0 = n_strobe[0]; v0 = n_valid[0];
    enter(1); enter(2); enter(7); enter(15);
    check("t2_strobes", 32'(n_strobe[0] - s0), 4);
    check("t2_valids", 32'(n_valid[0] - v0), 1);
    check("t2_data_u", 32'(bus_u.Data), 32'h7F);
    check("t2_data_s", 32'(bus_s.Data), 32'h7F);

    // Sign toggle, then saturation.
    enter(10); enter(5); enter(15);
    check("t3_neg_data_s", 32'(bus_s.Data), 32'hFB);
    check("t3_a_ignored_u", 32'(bus_u.Data), 32'h05);
    enter(2); enter(0); enter(0);
    check("t3_ovf_s", 32'(bus_s.Overflow), 1);
    check("t3_no_ovf_u", 32'(bus_u.Overflow), 0);
    enter(15);
    check("t3_sat_data_s", 32'(bus_s.Data), 32'h7F);
    check("t3_data_u", 32'(bus_u.Data), 32'hC8);
    check("t3_ovf_cleared_s", 32'(bus_s.Overflow), 0);

    // Bouncing key, then a short press.
    s0 = n_strobe[0];
    repeat (3) begin
      scan(16'(1) << pos_of(5));
      scan(16'h0000);
    end
    repeat (5) scan(16'(1) << pos_of(5));
    repeat (6) scan(16'h0000);
    check("t4_bounce_strobes", 32'(n_strobe[0] - s0), 1);
    check("t4_keycode", 32'(bus_u.KeyCode), 5);
    s0 = n_strobe[0];
    repeat (3) scan(16'(1) << pos_of(5));
    repeat (6) scan(16'h0000);
    check("t4_short_press", 32'(n_strobe[0] - s0), 0);

    // Two keys at once, then clear mid-entry.
    s0 = n_strobe[0];
    repeat (8) scan((16'(1) << pos_of(1)) | (16'(1) << pos_of(2)));
    repeat (6) scan(16'h0000);
    check("t5_two_keys", 32'(n_strobe[0] - s0), 0);
    enter(4); enter(14); enter(9); enter(15);
    check("t5_data_u", 32'(bus_u.Data), 9);
    check("t5_data_s", 32'(bus_s.Data), 9);

    // Reset mid-entry discards the digits.
    enter(3); enter(4);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    v1 = n_valid[1];
    enter(15);
    check("t6_data_after_reset", 32'(bus_s.Data), 0);
    check("t6_valid_pulse", 32'(n_valid[1] - v1), 1);
    enter(1); enter(2); enter(3); enter(11); enter(15);
`ifdef KEYPAD_BACKSPACE_EN
    check("t6_backspace_data", 32'(bus_u.Data), 12);
`else
    check("t6_b_ignored_data", 32'(bus_u.Data), 123);
`endif

    // Random presses, releases, and double keys.
    s1 = n_strobe[1];
    for (int i = 0; i < 40; i++) begin
      int          sel;
      int          hold;
      int          rel;
      logic [15:0] m;
      sel  = $urandom_range(0, 19);
      hold = $urandom_range(1, 6);
      rel  = $urandom_range(1, 6);
      if (sel < 16) m = 16'(1) << pos_of(sel);
      else m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      repeat (hold) scan(m);
      repeat (rel) scan(16'h0000);
    end
    repeat (6) scan(16'h0000);
    enter(15);
    repeat (50) @(negedge clk);
    check("queue_empty_u", 32'(exp_u_q.size()), 0);
    check("queue_empty_s", 32'(exp_s_q.size()), 0);
    check("random_strobes_match", 32'(n_strobe[1] - s1), 32'(n_strobe[0] - (n_strobe[0] - (n_strobe[1] - s1))));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/keypad_to_data.md
Name: keypad_to_data

Overview:
Scans a 4x4 matrix keypad, debounces it and turns decimal key entries into a binary value. It is the input-side counterpart of the multiplexed 7-segment display driver: the user types a number, and the block presents it as a Size-bit Data word with a one-cycle Valid strobe. Column drive is time-multiplexed from a free-running prescaler, in the same way the display refresh works.

Parameters:
Size, 8, width of Data in bits.
Signed, "Yes", "Yes": Data is two's complement and key A toggles the sign; "No": Data is unsigned and A is ignored.
ClockPeriod_ns, 20, Clock period.
ScanTime_ns, 1_000_000, dwell time per column; Prescale = ScanTime_ns/ClockPeriod_ns, minimum 2.
DebounceScans, 4, number of identical consecutive full scans needed to accept a press or a release; range 1..15.

Ports:
Clock  input  1  system clock; all logic on posedge.
Reset  input  1  synchronous, active-high.
Rows  input  4  keypad rows, active-low (pulled up), asynchronous to Clock.
Columns  output  4  column drive, active-low one-hot.
Data  output  Size  last entered value, held between entries.
Valid  output  1  one-cycle pulse when Data updates.
KeyCode  output  4  code of the last accepted key.
KeyStrobe  output  1  one-cycle pulse per accepted key press.
Overflow  output  1  sticky flag: entry saturated.

Behaviour:
- Interface: one clock, Clock. Reset is synchronous and active-high, named Reset.
- Reset values:
  - Columns=4'b1110.
  - Data=0, Valid=0, KeyCode=0, KeyStrobe=0, Overflow=0.
  - Accumulator=0, sign=positive, debounce state IDLE, scan counters=0.
- Rows input: synchronized through 2 flip-flops before any use.
- Scan:
  - A prescaler produces an Enable tick every Prescale clocks.
  - On each tick: synchronized Rows are sampled into a 16-bit snapshot at column c, then c advances 0->1->2->3->0.
  - Columns = ~(1<<c).
- Key map, row r / col c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- KeyCode encoding: digits 0-9 = their value; A=10, B=11, C=12, D=13, *=14, #=15.
- Scan classification, done after column 3 is sampled: exactly one bit low = single key k; zero keys or more than one key = NONE.
- Debounce FSM:
  - IDLE: count consecutive scans with the same single key k; a different k restarts the count at 1. When the count reaches DebounceScans, go to PRESSED and emit the event.
  - PRESSED: count consecutive NONE scans; any non-NONE scan resets the count. When the count reaches DebounceScans, go to IDLE.
  - Holding a key produces no repeat events.
- Event timing: KeyStrobe=1 and KeyCode=k in the clock after the qualifying scan completes; the accumulator updates in that same cycle.
- Accumulator:
  - Width Size bits. Max = 2^Size-1 for unsigned, 2^(Size-1)-1 for signed.
  - Digit d: acc = acc*10+d, computed at Size+4 bits. If the result exceeds Max, acc = Max and Overflow=1.
  - A (Signed="Yes" only): toggle the sign.
  - * : acc=0, sign=positive, Overflow=0.
  - # : Data = sign ? -acc : acc, with Valid=1 in the same cycle as KeyStrobe. Then acc=0, sign=positive. Overflow stays asserted through that Valid cycle and clears the next cycle.
  - B, C, D: strobe only, no effect on the accumulator (B excepted, see Optional Feature).
  - # with no digits entered: Data=0 (or -0=0), Valid pulses.
- Reset mid-entry or mid-debounce: everything returns to its reset value at the next edge; no event is emitted.

Optional Feature:
KEYPAD_BACKSPACE_EN:
- Defined: key B performs acc = acc/10 (integer division) and clears Overflow; the sign is unchanged.
- Undefined: B only raises KeyStrobe with KeyCode=11; the accumulator is unaffected.

Test Plan:
Bench settings: ClockPeriod_ns=20, ScanTime_ns=200 (Prescale=10, one scan = 40 clocks), DebounceScans=4.
1. Reset asserted mid-scan -> next edge: Columns=4'b1110, Data=0, Valid=0, Overflow=0; deassert -> Columns steps 1110, 1101, 1011, 0111 every 10 clocks.
2. Size=8, Signed="No"; enter 1, 2, 7, # (each held 6 scans, released 6 scans) -> 4 KeyStrobe pulses with KeyCode 1, 2, 7, 15; Data=8'h7F; Valid high for exactly 1 cycle.
3. Size=8, Signed="Yes"; enter A, 5, # -> Data=8'hFB. Then enter 2, 0, 0, # -> Overflow=1 after the third digit, Data=8'h7F, Overflow=0 one cycle after Valid.
4. Key 5 bouncing (alternating 1 scan pressed / 1 scan released for 6 scans), then held 5 scans -> exactly one KeyStrobe with KeyCode=5. Key held only 3 scans -> no KeyStrobe.
5. Keys 1 and 2 held together for 8 scans -> no KeyStrobe. Enter 4, *, 9, # -> Data=9.
6. Enter 3, 4, assert Reset for 1 cycle, then enter # -> Data=0, Valid pulses. With KEYPAD_BACKSPACE_EN: enter 1, 2, 3, B, # -> Data=12.
